// File: rtl/ifft_reg_responder.sv
`default_nettype none
// ============================================================================
// ifft_reg_responder : FrontPanel register-bridge target for IFFT control and
//                      the coefficient-RAM window. Option: IFFT_REG_TIMEOUT_EN
// Revision: 1.0
// ============================================================================
module ifft_reg_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MEM_AW    = 10,
    parameter int          TIMEOUT   = 255
) (
    input  logic              okClk,
    input  logic              reset_n,
    input  logic              ep_write,
    input  logic              ep_read,
    input  logic [31:0]       ep_address,
    input  logic [31:0]       ep_dataout,
    output logic [31:0]       ep_datain,
    output logic              ifft_enable,
    output logic [15:0]       ifft_scale,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2} state_t;

    state_t            state;
    logic [MEM_AW-1:0] bin_addr;
    logic [31:0]       shadow;
    logic              err;
    logic [15:0]       err_count;
    logic              prefetch_pending;

    logic              hit;
    logic [2:0]        offset;
    logic              wr_hit;
    logic              rd_hit;
    logic              wr_ctrl;
    logic              wr_status;
    logic              wr_scale;
    logic              wr_bin_addr;
    logic              wr_bin_data;
    logic              wr_err_count;
    logic              rd_bin_data;
    logic              bin_access;
    logic              soft_reset;
    logic              busy;
    logic              bin_busy;
    logic              bin_error;
    logic              timeout_abort;
    logic              timeout_bit;
    logic              err_event;
    logic [MEM_AW-1:0] bin_next;

    assign hit          = (ep_address[31:3] == BASE_ADDR[31:3]);
    assign offset       = ep_address[2:0];
    assign wr_hit       = ep_write && hit;
    assign rd_hit       = ep_read && hit;
    assign wr_ctrl      = wr_hit && (offset == 3'd0);
    assign wr_status    = wr_hit && (offset == 3'd1);
    assign wr_scale     = wr_hit && (offset == 3'd2);
    assign wr_bin_addr  = wr_hit && (offset == 3'd3);
    assign wr_bin_data  = wr_hit && (offset == 3'd4);
    assign wr_err_count = wr_hit && (offset == 3'd5);
    assign rd_bin_data  = rd_hit && (offset == 3'd4);
    assign bin_access   = (wr_hit || rd_hit) && ((offset == 3'd3) || (offset == 3'd4));
    assign soft_reset   = wr_ctrl && ep_dataout[1];
    assign busy         = (state != IDLE);
    // The cycle between soft-reset release and its prefetch also blocks the BIN path.
    assign bin_busy     = busy || prefetch_pending;
    assign bin_error    = bin_access && bin_busy && !soft_reset;
    assign err_event    = bin_error || timeout_abort;
    assign bin_next     = bin_addr + 1'b1;

`ifdef IFFT_REG_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT + 1);

    logic [TCW-1:0] ack_timer;
    logic           timeout_flag;

    assign timeout_abort = mem_req && !mem_ack && !soft_reset && (ack_timer == TCW'(TIMEOUT - 1));
    assign timeout_bit   = timeout_flag;

    always_ff @(posedge okClk or negedge reset_n) begin
        if (!reset_n) begin
            ack_timer    <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (mem_req && !mem_ack && !timeout_abort && !soft_reset)
                ack_timer <= ack_timer + 1'b1;
            else
                ack_timer <= '0;
            if (soft_reset)
                timeout_flag <= 1'b0;
            else if (timeout_abort)
                timeout_flag <= 1'b1;
            else if (wr_status && ep_dataout[2])
                timeout_flag <= 1'b0;
        end
    end
`else
    logic unused_timeout;

    assign timeout_abort  = 1'b0;
    assign timeout_bit    = 1'b0;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    always_ff @(posedge okClk or negedge reset_n) begin
        if (!reset_n) begin
            ep_datain        <= 32'd0;
            ifft_enable      <= 1'b0;
            ifft_scale       <= 16'd0;
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= 32'd0;
            state            <= IDLE;
            bin_addr         <= '0;
            shadow           <= 32'd0;
            err              <= 1'b0;
            err_count        <= 16'd0;
            prefetch_pending <= 1'b0;
        end else begin
            if (rd_hit) begin
                case (offset)
                    3'd0:    ep_datain <= {31'd0, ifft_enable};
                    3'd1:    ep_datain <= {29'd0, timeout_bit, err, busy};
                    3'd2:    ep_datain <= {16'd0, ifft_scale};
                    3'd3:    ep_datain <= 32'(bin_addr);
                    3'd4:    ep_datain <= shadow;
                    3'd5:    ep_datain <= {16'd0, err_count};
                    default: ep_datain <= 32'd0;
                endcase
            end

            if (wr_ctrl)  ifft_enable <= ep_dataout[0];
            if (wr_scale) ifft_scale  <= ep_dataout[15:0];

            if (soft_reset) begin
                err       <= 1'b0;
                err_count <= 16'd0;
            end else begin
                if (err_event)
                    err <= 1'b1;
                else if (wr_status && ep_dataout[1])
                    err <= 1'b0;
                // A new error in the same cycle as a clear leaves exactly one counted.
                if (err_event)
                    err_count <= wr_err_count ? 16'd1 :
                                 (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
                else if (wr_err_count)
                    err_count <= 16'd0;
            end

            if (soft_reset) begin
                state            <= IDLE;
                mem_req          <= 1'b0;
                mem_we           <= 1'b0;
                shadow           <= 32'd0;
                bin_addr         <= '0;
                prefetch_pending <= 1'b1;
            end else if (prefetch_pending) begin
                prefetch_pending <= 1'b0;
                state            <= RD;
                mem_req          <= 1'b1;
                mem_we           <= 1'b0;
                mem_addr         <= bin_addr;
            end else begin
                case (state)
                    IDLE: begin
                        if (wr_bin_data) begin
                            state     <= WR;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= bin_addr;
                            mem_wdata <= ep_dataout;
                        end else if (wr_bin_addr) begin
                            bin_addr <= ep_dataout[MEM_AW-1:0];
                            state    <= RD;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= ep_dataout[MEM_AW-1:0];
                        end else if (rd_bin_data) begin
                            bin_addr <= bin_next;
                            state    <= RD;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= bin_next;
                        end
                    end
                    WR: begin
                        if (mem_ack) begin
                            bin_addr <= bin_next;
                            mem_addr <= bin_next;
                            mem_we   <= 1'b0;
                            state    <= RD;
                        end else if (timeout_abort) begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                        end
                    end
                    RD: begin
                        if (mem_ack) begin
                            shadow  <= mem_rdata;
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end else if (timeout_abort) begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifft_reg_responder.sv
`default_nettype none
// tb_ifft_reg_responder : vector table for register behaviour, hand-written
// sequences for RAM transactions, busy errors, soft reset and timeout.
module tb_ifft_reg_responder;

    localparam int MEM_AW = 10;

    logic              okClk = 1'b0;
    logic              reset_n = 1'b0;
    logic              ep_write = 1'b0;
    logic              ep_read = 1'b0;
    logic [31:0]       ep_address = 32'd0;
    logic [31:0]       ep_dataout = 32'd0;
    logic [31:0]       ep_datain;
    logic              ifft_enable;
    logic [15:0]       ifft_scale;
    logic              mem_req;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack = 1'b0;
    logic [31:0]       mem_rdata = 32'd0;

    logic [31:0] ram [0:1023];
    int          ack_delay = 0;
    logic        never_ack = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    ifft_reg_responder #(
        .BASE_ADDR (32'h0000_0000),
        .MEM_AW    (MEM_AW),
        .TIMEOUT   (255)
    ) dut (
        .okClk      (okClk),
        .reset_n    (reset_n),
        .ep_write   (ep_write),
        .ep_read    (ep_read),
        .ep_address (ep_address),
        .ep_dataout (ep_dataout),
        .ep_datain  (ep_datain),
        .ifft_enable(ifft_enable),
        .ifft_scale (ifft_scale),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 okClk = ~okClk;

    // RAM model: acks ack_delay cycles after seeing mem_req, one-cycle ack pulse.
    initial begin : responder
        int cnt;
        cnt = 0;
        forever begin
            @(negedge okClk);
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req && !never_ack) begin
                if (cnt >= ack_delay) begin
                    cnt     = 0;
                    mem_ack = 1'b1;
                    if (mem_we) ram[mem_addr] = mem_wdata;
                    else        mem_rdata = ram[mem_addr];
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic        chk;
        logic [31:0] exp;
        int          settle;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    function automatic vec_t vw(input logic [31:0] a, input logic [31:0] d, input int s);
        vec_t v;
        v = '{1'b1, 1'b0, a, d, 1'b0, 32'd0, s};
        return v;
    endfunction

    function automatic vec_t vr(input logic [31:0] a, input logic [31:0] e, input int s);
        vec_t v;
        v = '{1'b0, 1'b1, a, 32'd0, 1'b1, e, s};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        @(negedge okClk);
        ep_write   = w;
        ep_read    = r;
        ep_address = a;
        ep_dataout = d;
        @(negedge okClk);
        ep_write = 1'b0;
        ep_read  = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus(1'b0, 1'b1, a, 32'd0);
        check(name, ep_datain, exp);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        @(negedge okClk);
        while (mem_req && n < budget) begin
            @(negedge okClk);
            n++;
        end
        if (mem_req) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: mem_req still 1 after %0d cycles, expected 0", name, budget);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'd0;
        ram[1023] = 32'h11;
        ram[0]    = 32'h22;
        ram[1]    = 32'h33;
        ram[2]    = 32'h55;
        ram[5]    = 32'h5555_5555;
        ram[6]    = 32'h66;
        ram[7]    = 32'h77;

        vecs[0]  = vr(32'h0, 32'h0, 0);
        vecs[1]  = vr(32'h1, 32'h0, 0);
        vecs[2]  = vr(32'h2, 32'h0, 0);
        vecs[3]  = vr(32'h3, 32'h0, 0);
        vecs[4]  = vr(32'h4, 32'h0, 0);
        vecs[5]  = vr(32'h5, 32'h0, 0);
        vecs[6]  = vw(32'h2, 32'h1234_ABCD, 0);
        vecs[7]  = vr(32'h2, 32'h0000_ABCD, 0);
        vecs[8]  = vr(32'h6, 32'h0, 0);
        vecs[9]  = vr(32'h2, 32'h0000_ABCD, 0);
        vecs[10] = vr(32'h7, 32'h0, 0);
        vecs[11] = vw(32'h7, 32'hFFFF_FFFF, 0);
        vecs[12] = vr(32'h7, 32'h0, 0);
        vecs[13] = vw(32'h0, 32'h1, 0);
        vecs[14] = vr(32'h0, 32'h1, 0);
        vecs[15] = vw(32'hA, 32'h9999, 0);
        vecs[16] = vr(32'h2, 32'h0000_ABCD, 0);
        vecs[17] = vr(32'h0, 32'h1, 0);
        vecs[18] = vr(32'h12, 32'h1, 0);
        vecs[19] = vw(32'h3, 32'h3FF, 4);
        vecs[20] = vr(32'h3, 32'h3FF, 0);
        vecs[21] = vr(32'h4, 32'h11, 4);
        vecs[22] = vr(32'h3, 32'h0, 0);
        vecs[23] = vr(32'h4, 32'h22, 4);
        vecs[24] = vr(32'h3, 32'h1, 0);
        vecs[25] = vr(32'h1, 32'h0, 0);
        vecs[26] = vr(32'h5, 32'h0, 0);

        // Reset state
        repeat (3) @(negedge okClk);
        check("rst_datain", ep_datain, 32'd0);
        check("rst_enable", 32'(ifft_enable), 32'd0);
        check("rst_scale", 32'(ifft_scale), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge okClk);
        check("no_auto_prefetch", 32'(mem_req), 32'd0);

        for (int i = 0; i < NV; i++) begin
            bus(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data);
            if (vecs[i].chk) check($sformatf("vec%0d", i), ep_datain, vecs[i].exp);
            repeat (vecs[i].settle) @(negedge okClk);
        end
        check("scale_out", 32'(ifft_scale), 32'h0000_ABCD);
        check("enable_out", 32'(ifft_enable), 32'd1);

        // BIN_DATA write with 1-cycle ack, then chained prefetch of the next address
        bus(1'b1, 1'b0, 32'h3, 32'd5);
        wait_idle("a_addr_idle", 20);
        bus(1'b1, 1'b0, 32'h4, 32'hCAFE_0001);
        check("a_wr_req", 32'(mem_req), 32'd1);
        check("a_wr_we", 32'(mem_we), 32'd1);
        check("a_wr_addr", 32'(mem_addr), 32'd5);
        check("a_wr_data", mem_wdata, 32'hCAFE_0001);
        @(negedge okClk);
        check("a_rd_req", 32'(mem_req), 32'd1);
        check("a_rd_we", 32'(mem_we), 32'd0);
        check("a_rd_addr", 32'(mem_addr), 32'd6);
        wait_idle("a_idle", 20);
        rd_check("a_bin_addr", 32'h3, 32'd6);
        check("a_ram5", ram[5], 32'hCAFE_0001);

        // Second BIN_DATA write while busy is dropped and counted
        ack_delay = 20;
        bus(1'b1, 1'b0, 32'h4, 32'h0000_D00D);
        bus(1'b1, 1'b0, 32'h4, 32'h0000_BEEF);
        rd_check("b_status_err", 32'h1, 32'h3);
        rd_check("b_err_count", 32'h5, 32'h1);
        bus(1'b1, 1'b0, 32'h1, 32'h2);
        rd_check("b_status_clr", 32'h1, 32'h1);
        wait_idle("b_idle", 200);
        check("b_ram6", ram[6], 32'h0000_D00D);
        rd_check("b_status_idle", 32'h1, 32'h0);
        rd_check("b_err_count_kept", 32'h5, 32'h1);
        rd_check("b_bin_addr", 32'h3, 32'd7);

        // Soft reset in the middle of a prefetch
        bus(1'b1, 1'b0, 32'h3, 32'd9);
        bus(1'b1, 1'b0, 32'h0, 32'h3);
        check("c_req_dropped", 32'(mem_req), 32'd0);
        check("c_enable", 32'(ifft_enable), 32'd1);
        @(negedge okClk);
        check("c_prefetch_req", 32'(mem_req), 32'd1);
        check("c_prefetch_we", 32'(mem_we), 32'd0);
        check("c_prefetch_addr", 32'(mem_addr), 32'd0);
        rd_check("c_ctrl", 32'h0, 32'h1);
        rd_check("c_err_count", 32'h5, 32'h0);
        rd_check("c_status_busy", 32'h1, 32'h1);
        check("c_scale_kept", 32'(ifft_scale), 32'h0000_ABCD);
        wait_idle("c_idle", 200);
        rd_check("c_bin_addr", 32'h3, 32'd0);

        // Simultaneous BIN_DATA write and read: write wins, no extra increment
        ack_delay = 0;
        rd_check("d_shadow0", 32'h4, 32'h22);
        wait_idle("d_idle0", 20);
        bus(1'b1, 1'b1, 32'h4, 32'h44);
        check("d_sim_read", ep_datain, 32'h33);
        wait_idle("d_idle1", 20);
        rd_check("d_bin_addr", 32'h3, 32'd2);
        check("d_ram1", ram[1], 32'h44);
        rd_check("d_err_count", 32'h5, 32'h0);
        rd_check("d_shadow2", 32'h4, 32'h55);
        wait_idle("d_idle2", 20);

`ifdef IFFT_REG_TIMEOUT_EN
        begin : timeout_seq
            int hi;
            never_ack = 1'b1;
            bus(1'b1, 1'b0, 32'h4, 32'h0000_0077);
            hi = 0;
            while (mem_req && hi < 400) begin
                hi++;
                @(negedge okClk);
            end
            check("t_req_cycles", 32'(hi), 32'd255);
            never_ack = 1'b0;
            rd_check("t_status", 32'h1, 32'h6);
            rd_check("t_bin_addr", 32'h3, 32'd3);
            rd_check("t_err_count", 32'h5, 32'h1);
            bus(1'b1, 1'b0, 32'h1, 32'h6);
            rd_check("t_status_clr", 32'h1, 32'h0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ifft_reg_responder.md
# ifft_reg_responder

Register-bridge responder (target end) for the IFFT control path in the okClk domain. Decodes FrontPanel register-bridge writes and reads, holds the IFFT control registers, and returns read data on `ep_datain`. Also exposes a coefficient-RAM window: an address register and a data port. Accesses through the data port turn into req/ack transactions on a memory port, with prefetch and auto-increment.

## Interface
- `BASE_ADDR`, 32'h0000_0000: address of register 0; only `ep_address[31:3] == BASE_ADDR[31:3]` is decoded.
- `MEM_AW`, 10: coefficient RAM address width.
- `TIMEOUT`, 255: ack timeout in cycles; used only with `IFFT_REG_TIMEOUT_EN`.

Ports:
- `okClk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ep_write`  in  1  one-cycle write strobe.
- `ep_read`  in  1  one-cycle read strobe.
- `ep_address`  in  32  register address, valid with strobe.
- `ep_dataout`  in  32  write data, valid with `ep_write`.
- `ep_datain`  out  32  read data.
- `ifft_enable`  out  1  CTRL[0].
- `ifft_scale`  out  16  SCALE[15:0].
- `mem_req`  out  1  RAM request, held until ack.
- `mem_we`  out  1  1 = write, 0 = read; stable while `mem_req`.
- `mem_addr`  out  MEM_AW  RAM address.
- `mem_wdata`  out  32  RAM write data.
- `mem_ack`  in  1  completes the current request.
- `mem_rdata`  in  32  read data, valid with `mem_ack` when `mem_we = 0`.

## Operation
Register map (offset = `ep_address[2:0]`):
- 0 CTRL (RW): bit0 enable; bit1 soft_reset (self-clearing, always reads 0).
- 1 STATUS (RO): bit0 busy; bit1 err (sticky); bit2 timeout (sticky). Writing offset 1 with bit1/bit2 set clears those bits.
- 2 SCALE (RW, 16 bits, upper bits read 0).
- 3 BIN_ADDR (RW, MEM_AW bits).
- 4 BIN_DATA: reads return the shadow register; writes go to RAM.
- 5 ERR_COUNT (RO, 16 bits, saturates at 0xFFFF; any write to offset 5 clears it).
- 6 and 7: reads return 0, writes are ignored.
- Addresses outside the decoded range are ignored and leave `ep_datain` unchanged.

FSM states are IDLE, WR and RD; busy = (state != IDLE).
- IDLE to WR: a write to BIN_DATA latches `mem_wdata` = data and `mem_addr` = BIN_ADDR.
- IDLE to RD (prefetch of BIN_ADDR) on any of:
  - a write to BIN_ADDR;
  - a read of BIN_DATA, which first increments BIN_ADDR;
  - release of soft reset.
- WR on ack: BIN_ADDR increments, then RD to prefetch the new address.
- RD on ack: shadow = `mem_rdata`, then IDLE.
- Any BIN_ADDR or BIN_DATA access while busy is dropped, sets err and increments ERR_COUNT. A BIN_DATA read while busy still returns the current shadow.
- BIN_ADDR wraps from 2^MEM_AW−1 to 0.
- Simultaneous `ep_write` and `ep_read`: both are decoded. If both touch the BIN path in IDLE, the write wins and the read does not increment BIN_ADDR.
- soft_reset:
  - forces the FSM to IDLE and drops `mem_req` the next cycle;
  - clears shadow, BIN_ADDR, err, timeout and ERR_COUNT;
  - leaves CTRL[0] and SCALE unchanged;
  - starts a prefetch of address 0 one cycle later.

## Timing
- Reset values: `ep_datain`=0, `ifft_enable`=0, `ifft_scale`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0. State is IDLE and shadow=0.
- After reset release, the FSM stays IDLE; there is no automatic prefetch.
- `ep_datain` is registered. It is valid on the cycle after `ep_read` and holds until the next decoded read.
- Register writes take effect on the cycle after `ep_write`.
- `mem_req` rises on the cycle after the triggering strobe.
- `mem_ack` is sampled on the clock edge. `mem_req` falls on the cycle after the ack edge, or rises again for the chained prefetch.
- Minimum BIN_DATA write turnaround with 1-cycle ack: 4 cycles back to IDLE.

## Configuration
- `IFFT_REG_TIMEOUT_EN` defined:
  - a counter runs while `mem_req` is high;
  - at TIMEOUT cycles without ack, the FSM aborts to IDLE, sets timeout and err, and increments ERR_COUNT;
  - on abort, BIN_ADDR is not incremented and shadow is not updated.
- Undefined: the FSM waits indefinitely for `mem_ack` and STATUS bit2 reads 0.

## Test plan
- Reset, then read offsets 0–5: every read returns 0. Write SCALE=0x1234_ABCD: `ifft_scale`=0xABCD and the read-back is 0x0000_ABCD.
- Write BIN_ADDR=5, then BIN_DATA=0xCAFE0001 with a 1-cycle ack model:
  - `mem_we=1`, `mem_addr=5`;
  - then a read request at addr 6;
  - BIN_ADDR then reads 6.
- Preload RAM[1023]=0x11, RAM[0]=0x22. Write BIN_ADDR=1023; read BIN_DATA twice: returns 0x11 then 0x22, and BIN_ADDR wraps to 0 then 1.
- With ack delayed 20 cycles, issue a second BIN_DATA write while busy: it is dropped, STATUS=0x3 and ERR_COUNT=1. Writing STATUS=0x2 clears err.
- With `IFFT_REG_TIMEOUT_EN` and TIMEOUT=255, never ack: `mem_req` drops after 255 cycles, STATUS bit2=1 and BIN_ADDR is unchanged.
- Write CTRL=0x3 mid-transaction: `ifft_enable`=1, `mem_req` drops, then a prefetch of address 0 starts, and CTRL reads 0x1.
